// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA timing generator for the Pong display path.
// Produces pixel coordinates, registered active-low syncs, video_on and a
// once-per-frame refr_tick at the start of vertical blank.
// Optional feature: define VGA_SYNC_TESTPAT_EN to drive an 8-bar colour test
// pattern on bar_rgb; without it bar_rgb is tied to 12'h000.
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        p_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        refr_tick,
  output logic [11:0] bar_rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic             hsync_next;
  logic             vsync_next;

  // With CLK_DIV=1 the divider never leaves 0, so p_tick is constantly high.
  assign p_tick = (div_reg == DIV_MAX);

  // Pixel-rate divider: count 0..CLK_DIV-1 and wrap.
  always_comb begin
    div_next = div_reg + 1'b1;
    if (p_tick) div_next = '0;
  end

  // Next raster position; only moves on a pixel tick.
  always_comb begin
    x_next = x;
    y_next = y;
    if (p_tick) begin
      if (x == H_MAX) begin
        x_next = '0;
        y_next = (y == V_MAX) ? 10'd0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  // Syncs are decoded from the next position so they stay aligned with x/y.
  always_comb begin
    hsync_next = !((x_next >= HS_START) && (x_next <= HS_END));
    vsync_next = !((y_next >= VS_START) && (y_next <= VS_END));
  end

  // Timing state; asynchronous reset restarts the raster at (0,0).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_reg <= '0;
      x       <= '0;
      y       <= '0;
      hsync   <= 1'b1;
      vsync   <= 1'b1;
    end else begin
      div_reg <= div_next;
      x       <= x_next;
      y       <= y_next;
      hsync   <= hsync_next;
      vsync   <= vsync_next;
    end
  end

  assign video_on  = (x < H_VIS) && (y < V_VIS);
  // p_tick qualifies the pulse so it is one clk wide regardless of CLK_DIV.
  assign refr_tick = p_tick && (x == 10'd0) && (y == V_VIS);

`ifdef VGA_SYNC_TESTPAT_EN
  localparam int BAR_W = H_DISPLAY / 8;

  logic [2:0]  bar_idx;
  logic [11:0] bar_colour;
  logic [11:0] bar_next;

  assign bar_idx = 3'(x_next / 10'(BAR_W));

  // Bar palette, left to right.
  always_comb begin
    bar_colour = 12'h000;
    case (bar_idx)
      3'd0: bar_colour = 12'h000;
      3'd1: bar_colour = 12'hF00;
      3'd2: bar_colour = 12'h0F0;
      3'd3: bar_colour = 12'h00F;
      3'd4: bar_colour = 12'hFF0;
      3'd5: bar_colour = 12'h0FF;
      3'd6: bar_colour = 12'hF0F;
      3'd7: bar_colour = 12'hFFF;
      default: bar_colour = 12'h000;
    endcase
  end

  // Blank the pattern outside the visible area of the next position.
  always_comb begin
    bar_next = 12'h000;
    if ((x_next < H_VIS) && (y_next < V_VIS)) bar_next = bar_colour;
  end

  // Register the pattern alongside the syncs so it lines up with x.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) bar_rgb <= 12'h000;
    else       bar_rgb <= bar_next;
  end
`else
  assign bar_rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized check of vga_sync_gen against an arithmetic
// raster model derived from the number of clk edges since reset release.
// Uses a shrunken raster so several frames fit in a short run.
// Honours VGA_SYNC_TESTPAT_EN for the expected bar_rgb.
module tb_vga_sync_gen;

  localparam int D  = 2;
  localparam int HD = 16, HF = 2, HS = 3, HB = 2;
  localparam int VD = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HD + HF + HS + HB;   // 23 pixels per line
  localparam int VT = VD + VF + VS + VB;   // 15 lines per frame
  localparam int FRC = HT * VT * D;        // clk cycles per frame

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  x, y;
  logic        p_tick, hsync, vsync, video_on, refr_tick;
  logic [11:0] bar_rgb;

  int errors = 0;
  int checks = 0;
  int unsigned cyc;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .CLK_DIV(D),
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rstn(rstn), .x(x), .y(y), .p_tick(p_tick),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .refr_tick(refr_tick), .bar_rgb(bar_rgb)
  );

  wire [36:0] obs = {x, y, p_tick, hsync, vsync, video_on, refr_tick, bar_rgb};

  // clk edges seen since reset was released
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after c edges: c/D pixels have elapsed since (0,0).
  function automatic logic [36:0] model(input int unsigned c);
    int unsigned pix, xx, yy;
    logic pt, hs, vs, vo, rt;
    logic [11:0] bar;
    pix = c / D;
    xx  = pix % HT;
    yy  = (pix / HT) % VT;
    pt  = (c % D) == D - 1;
    hs  = !(xx >= HD + HF && xx < HD + HF + HS);
    vs  = !(yy >= VD + VF && yy < VD + VF + VS);
    vo  = (xx < HD) && (yy < VD);
    rt  = pt && xx == 0 && yy == VD;
    bar = 12'h000;
`ifdef VGA_SYNC_TESTPAT_EN
    if (vo) begin
      case (xx / (HD / 8))
        0: bar = 12'h000;  1: bar = 12'hF00;  2: bar = 12'h0F0;  3: bar = 12'h00F;
        4: bar = 12'hFF0;  5: bar = 12'h0FF;  6: bar = 12'hF0F;  default: bar = 12'hFFF;
      endcase
    end
`endif
    return {10'(xx), 10'(yy), pt, hs, vs, vo, rt, bar};
  endfunction

  // Every cycle, compare all outputs with the model away from the active edge.
  always @(negedge clk) check_val("cycle", 64'(obs), 64'(model(cyc)));

  // Drop rstn between edges, confirm it acts at once, then hold and release.
  task automatic async_reset(input int offset, input int hold);
    #(offset) rstn = 1'b0;
    #1 check_val("async_rst", 64'(obs), 64'(model(0)));
    repeat (hold) @(negedge clk);
    #1 rstn = 1'b1;
  endtask

  initial begin
    int pulses, first, last, overlap, n, off, hold;
    pulses = 0; first = -1; last = -1; overlap = 0;

    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    $display("reset released at t=%0t", $time);

    // Three frames: count refresh pulses and their spacing.
    for (int i = 1; i <= 3 * FRC; i++) begin
      @(negedge clk);
      if (refr_tick) begin
        if (pulses == 0) first = i;
        else check_val("refr_gap", 64'(i - last), 64'(FRC));
        last = i;
        pulses++;
        if (video_on) overlap++;
      end
    end
    check_val("refr_count", 64'(pulses), 64'd3);
    check_val("refr_first", 64'(first), 64'(VD * HT * D + D - 1));
    check_val("refr_video", 64'(overlap), 64'd0);
    $display("three frames done: refr pulses=%0d", pulses);

    // Fresh start, run to a late position mid-frame, then reset there.
    async_reset(2, 2);
    repeat ((HT * (VD - 2) + HT - 3) * D) @(negedge clk);
    check_val("pos_x", 64'(x), 64'(HT - 3));
    check_val("pos_y", 64'(y), 64'(VD - 2));
    async_reset(2, 3);
    $display("mid-frame reset at x=%0d y=%0d done", HT - 3, VD - 2);

    // Random run lengths and reset phases.
    for (int k = 0; k < 6; k++) begin
      n    = $urandom_range(20, 900);
      off  = $urandom_range(1, 3);
      hold = $urandom_range(1, 4);
      repeat (n) @(negedge clk);
      async_reset(off, hold);
      $display("random reset %0d: after %0d cycles, offset %0d, hold %0d", k, n, off, hold);
    end
    repeat (2 * FRC) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Timing generator for the 640x480 @ 60 Hz VGA display path of the Pong design. It produces the pixel coordinates `x` and `y` that paddle and ball renderers compare against their positions. It also produces `hsync`, `vsync` and `video_on` for the DAC/connector, and the once-per-frame `refr_tick` that paces all object motion. It is the source of the coordinate and refresh interface that every object renderer consumes.

## Interface
- `CLK_DIV`, 2: `clk` cycles per pixel (50 MHz `clk` gives a 25 MHz pixel rate); must be ≥1.
- `H_DISPLAY`, 640: visible pixels per line.
- `H_FRONT`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BACK`, 48: horizontal back porch, in pixels.
- `V_DISPLAY`, 480: visible lines.
- `V_FRONT`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BACK`, 33: vertical back porch, in lines.
- `clk` input 1: system clock.
- `rstn` input 1: reset, asynchronous, active-low.
- `x` output 10: current pixel column, 0..H_TOTAL-1.
- `y` output 10: current line, 0..V_TOTAL-1.
- `p_tick` output 1: one-`clk` strobe; `x`/`y` advance on the following edge.
- `hsync` output 1: horizontal sync, active-low, registered.
- `vsync` output 1: vertical sync, active-low, registered.
- `video_on` output 1: high while `x<H_DISPLAY && y<V_DISPLAY`.
- `refr_tick` output 1: one-`clk` pulse per frame, at the start of vertical blank.
- `bar_rgb` output 12: test-pattern colour (see Configuration).

## Operation
- Totals: H_TOTAL = 640+16+96+48 = 800 pixels per line; V_TOTAL = 480+10+2+33 = 525 lines per frame.
- Divider: a counter `div` runs 0..CLK_DIV-1 and wraps. `p_tick` = (`div`==CLK_DIV-1). With CLK_DIV=1, `p_tick` is constantly 1.
- On each `clk` edge with `p_tick`=1:
  - `x`←`x`+1.
  - If `x`==H_TOTAL-1: `x`←0 and `y`←`y`+1.
  - If additionally `y`==V_TOTAL-1: `y`←0.
- `hsync` is registered from the next `x` value. It is 0 iff next `x` is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], which is [656,751] at defaults. Because it is computed from the next value, it stays aligned with `x`.
- `vsync` is registered from the next `y` value. It is 0 iff next `y` is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], which is [490,491] at defaults.
- `video_on` is decoded combinationally from the registered `x` and `y`.
- `refr_tick` = `p_tick` && `x`==0 && `y`==V_DISPLAY. It is exactly one `clk` wide, once per frame, independent of CLK_DIV.
- Coordinate arithmetic is 10-bit unsigned. Wrap occurs only at the totals, so no overflow is possible.
- Reset values: `div`=0, `x`=0, `y`=0, `hsync`=1, `vsync`=1.
  - `video_on`=1 (since 0,0 is visible).
  - `refr_tick`=0, `p_tick`=0 (for CLK_DIV>1).
  - `bar_rgb`=12'h000 when test pattern is disabled; otherwise the pattern value for column 0.
- A reset asserted mid-frame returns all state to the reset values immediately, because reset is asynchronous. After `rstn` rises, the timing restarts from (0,0) with no partial-line residue.

## Timing
- First `p_tick`: the CLK_DIV-th rising edge after `rstn` deasserts.
- `x`/`y`/`hsync`/`vsync` update on the same edge that samples `p_tick`=1. They are stable for CLK_DIV cycles.
- Latency from coordinate to sync output: 0 pixels. `hsync` falls on the same edge on which `x` becomes 656.
- Line period: 800×CLK_DIV `clk` cycles. Frame period: 420000×CLK_DIV `clk` cycles.
- `refr_tick` spacing: exactly one frame period.
- Consumers sample `refr_tick` in the `clk` domain. It never coincides with `video_on`=1.

## Configuration
- Macro: `VGA_SYNC_TESTPAT_EN`.
- Defined: `bar_rgb` is a registered 8-bar colour pattern.
  - Bar index = `x`/80 (0..7); colours in order 000, F00, 0F0, 00F, FF0, 0FF, F0F, FFF.
  - `bar_rgb` is forced to 000 when the next position is outside the visible area.
  - `bar_rgb` is aligned with `x` in the same way as `hsync`.
- Undefined: the pattern logic is absent and `bar_rgb` is tied to 12'h000.

## Test plan
- Reset, then release with CLK_DIV=2 → `p_tick` first high on the 2nd edge after release, then every 2nd cycle; `x` reads 0,0,1,1,2,…
- Run one line → `x` wraps from 799 to 0 and `y` goes 0→1 on the same edge. `hsync` is low for exactly 96 pixels, from `x`=656 through `x`=751.
- Run one full frame → `y` wraps from 524 to 0. `vsync` is low only on lines 490–491. The frame lasts 840000 `clk` cycles.
- Count `refr_tick` over 3 frames → exactly 3 pulses, each 1 `clk` wide, at `x`=0, `y`=480, spaced 840000 cycles apart.
- Assert `rstn`=0 at `x`=700, `y`=300 → all outputs take their reset values immediately (`x`=0, `y`=0, `hsync`=1, `vsync`=1). After release, the timing matches a fresh start.
- With `VGA_SYNC_TESTPAT_EN` defined → `bar_rgb`=F00 at `x`=100, FFF at `x`=639, and 000 at `x`=640. Without the macro, `bar_rgb` is 000 throughout.
